// File: rtl/mips_defs_pkg.sv
// Shared MIPS execute-stage definitions: multiply/divide op encodings and MD unit state type.
package mips_defs;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

    typedef enum logic {
        MD_ST_IDLE = 1'b0,
        MD_ST_RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit for multiple cycles (MULT, MULTU, DIV, DIVU).
    function automatic logic md_is_long(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_muldiv_unit.sv
// Execute-stage multiply/divide unit: architectural HI/LO plus a fixed-latency MULT/DIV engine
// whose result is computed at issue and committed when the latency counter expires.
module e_muldiv_unit
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    input  logic               d_uses_md,
    output logic [31:0]        hi,
    output logic [31:0]        lo,
    output logic               busy,
    output logic               stall_req
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      res_hi_q, res_hi_d;
    logic [31:0]      res_lo_q, res_lo_d;
    logic             res_wr_q, res_wr_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic        op_signed;
    logic [63:0] a_ext, b_ext, prod;
    logic        a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag, b_div;
    logic [31:0] q_mag, r_mag, quot, rem;

    // One shared 64-bit multiplier: sign-extending for MULT makes the low 64 bits of the
    // unsigned product equal the signed product.
    always_comb begin
        op_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
        a_ext     = {{32{op_signed & a[31]}}, a};
        b_ext     = {{32{op_signed & b[31]}}, b};
        prod      = a_ext * b_ext;
    end

    // Divide on magnitudes and restore signs afterwards; this keeps 0x80000000 / -1 well
    // defined (quotient wraps to 0x80000000, remainder 0) without an overflowing signed divide.
    always_comb begin
        a_neg  = op_signed & a[31];
        b_neg  = op_signed & b[31];
        a_mag  = a_neg ? (~a + 32'd1) : a;
        b_mag  = b_neg ? (~b + 32'd1) : b;
        b_zero = (b == 32'd0);
        b_div  = b_zero ? 32'd1 : b_mag;
        q_mag  = a_mag / b_div;
        r_mag  = a_mag % b_div;
        quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_wr_d = res_wr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            MD_ST_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            res_hi_d = prod[63:32];
                            res_lo_d = prod[31:0];
                            res_wr_d = 1'b1;
                            cnt_d    = MULT_N;
                            state_d  = MD_ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            res_hi_d = rem;
                            res_lo_d = quot;
                            res_wr_d = ~b_zero;
                            cnt_d    = DIV_N;
                            state_d  = MD_ST_RUN;
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            MD_ST_RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = MD_ST_IDLE;
                    if (res_wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end
            end
            default: state_d = MD_ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MD_ST_IDLE;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_wr_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_wr_q <= res_wr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = (state_q == MD_ST_RUN);
    assign stall_req = d_uses_md & (busy | (start & md_is_long(md_op)));

endmodule
